// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one FIFO write port between two requesters,
// with occupancy throttling and a bounded burst per grant.
module fifo_wr_arbiter #(
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] d_in0,
   input  logic [31:0] d_in1,
   input  logic [3:0]  data_count,
   output logic        gnt0,
   output logic        gnt1,
   output logic        acc0,
   output logic        acc1,
   output logic        wr_en,
   output logic [31:0] d_out
);

   // state | meaning
   // IDLE  | no owner, no write; arbitrates ties with 'last'
   // G0    | requester 0 owns the write port
   // G1    | requester 1 owns the write port
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [2:0] BEAT_LAST = 3'(MAX_BURST - 1);

   state_t     state, state_nxt;
   logic       last, last_nxt;
   logic [2:0] beat_cnt, beat_nxt;
   logic       room;
   logic       wr_ok;

   assign room = (data_count < 4'(DEPTH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         beat_cnt <= 3'd0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      beat_nxt  = beat_cnt;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      acc0      = 1'b0;
      acc1      = 1'b0;
      wr_ok     = 1'b0;
      d_out     = 32'h0;

      case (state)
         IDLE: begin
            beat_nxt = 3'd0;
            if (req0 && req1) state_nxt = last ? G0 : G1;
            else if (req0)    state_nxt = G0;
            else if (req1)    state_nxt = G1;
         end

         G0: begin
            gnt0  = 1'b1;
            d_out = d_in0;
            wr_ok = req0 && room;
            acc0  = wr_ok;
            if (!req0) begin
               last_nxt  = 1'b0;
               beat_nxt  = 3'd0;
               state_nxt = req1 ? G1 : IDLE;
            end else if (wr_ok) begin
               // burst limit: the last word still goes out on this edge
               if (beat_cnt == BEAT_LAST) begin
                  last_nxt = 1'b0;
                  beat_nxt = 3'd0;
                  if (req1) state_nxt = G1;
               end else begin
                  beat_nxt = beat_cnt + 3'd1;
               end
            end
         end

         G1: begin
            gnt1  = 1'b1;
            d_out = d_in1;
            wr_ok = req1 && room;
            acc1  = wr_ok;
            if (!req1) begin
               last_nxt  = 1'b1;
               beat_nxt  = 3'd0;
               state_nxt = req0 ? G0 : IDLE;
            end else if (wr_ok) begin
               if (beat_cnt == BEAT_LAST) begin
                  last_nxt = 1'b1;
                  beat_nxt = 3'd0;
                  if (req0) state_nxt = G0;
               end else begin
                  beat_nxt = beat_cnt + 3'd1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            beat_nxt  = 3'd0;
         end
      endcase

      wr_en = wr_ok;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port scheduler that shares one 8-entry, 32-bit FIFO write port between two requesters.
- Grants one requester at a time and forwards that requester's data and write strobe to the FIFO.
- Throttles on FIFO occupancy and forces a grant rotation after a bounded burst, so neither requester can starve the other.
- Sits between the two producer blocks and the FIFO's d_in/wr_en inputs; the FIFO read side is untouched.

Parameters:
- DEPTH, 8, FIFO capacity in words; writes are suppressed when data_count equals DEPTH.
- MAX_BURST, 4, maximum accepted words per grant before forced rotation; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 has a word on d_in0; held high until its burst ends
- req1  input  1  requester 1 has a word on d_in1
- d_in0  input  32  requester 0 write data
- d_in1  input  32  requester 1 write data
- data_count  input  4  FIFO occupancy, registered in the FIFO, 0..8
- gnt0  output  1  requester 0 owns the port (registered state decode)
- gnt1  output  1  requester 1 owns the port
- acc0  output  1  requester 0 word is written at this clock edge; requester advances its data next cycle
- acc1  output  1  requester 1 word is written at this clock edge
- wr_en  output  1  FIFO write enable
- d_out  output  32  FIFO write data (connects to FIFO d_in)

Behaviour:
- State register (2 bits): IDLE=0, G0=1, G1=2. Other registers: last (1 bit, last requester served) and beat_cnt (3 bits).
- Reset: state=IDLE, last=1 (so requester 0 wins the first tie), beat_cnt=0. All outputs read 0, including d_out=32'h0.
- Reset is asynchronous; mid-burst assertion drops wr_en and both grants immediately. Words already accepted stay in the FIFO.
- gnt0 = (state==G0); gnt1 = (state==G1).
- room = (data_count < DEPTH).
- wr_en = (G0 & req0 & room) | (G1 & req1 & room).
- acc0 = G0 & wr_en; acc1 = G1 & wr_en.
- d_out = d_in0 in G0, d_in1 in G1, 0 in IDLE.
- Grant latency: one cycle. A request seen in IDLE produces a grant on the next cycle. No write ever occurs in IDLE.
- IDLE transitions:
  - req0 & req1: go to G0 if last==1, else G1.
  - Only one request high: go to that requester's state.
  - No request: stay in IDLE.
  - beat_cnt is cleared on entering any grant state.
- G0 transitions (G1 is symmetric with indices swapped):
  - req0 low: release. Go to G1 if req1, else IDLE. Set last=0.
  - acc0 and beat_cnt==MAX_BURST-1 (burst limit): set last=0. Go to G1 if req1. Otherwise stay in G0 with beat_cnt=0 (re-grant with no competitor; no idle bubble).
  - acc0 below the limit: beat_cnt+1, stay in G0.
  - req0 high, FIFO full (no acc0): stall in G0 with beat_cnt held. No rotation on stall, and no timeout.
- Simultaneous events:
  - Burst limit hit while req1 is high: the switch happens on that edge, and the final G0 word is still written.
  - FIFO drains during a stall: room is recomputed each cycle from data_count and the write resumes the same cycle.
- Requester rule: data must be stable while req is high and acc is low. A requester may lower req only after an acc, or while not granted.
- The arbiter never drives wr_en when data_count==DEPTH, so the FIFO wr_err must never assert from this path.

Test Plan:
- Reset, then req0=1 alone with d_in0 incrementing from 32'h10 on each acc0: gnt0 rises 1 cycle after req0. Four acc0 pulses (10,11,12,13), then beat_cnt=0 and G0 is kept with no gap. FIFO receives 10..13 in order.
- req0 and req1 both high from reset: grant order G0 x4, G1 x4, G0 x4. acc pulses alternate in blocks of 4 and last toggles on each rotation.
- data_count held at 8 while in G1 with req1=1: wr_en=0, acc1=0, and G1 and beat_cnt hold for 10 cycles. Drop data_count to 7: wr_en=1 in that same cycle.
- G0 with beat_cnt=2, req0 drops while req1=1: next cycle gnt1=1 and beat_cnt=0. No spurious write in the transition cycle.
- reset_n pulsed low mid-burst in G1 at beat 2: gnt1, wr_en, acc1 and d_out go 0 immediately. After release, with both requesting, G0 is granted first (last=1).
- Throughout a random req0/req1 run of 1000 cycles driving the real FIFO: wr_err never 1, and no requester waits more than MAX_BURST+1 cycles for a grant while the FIFO has room.
